wb_arbiter: RTL and testbench

Writeback arbiter and pending-write scoreboard for the integer register file. Merges results from the single-cycle ALU, the load unit and the quantum measurement unit into the register file's single write port (we/rd/wd), one write per cycle. Tracks destination registers of in-flight long-latency ops so decode can stall on RAW hazards. Sits between the execute/memory/quantum units and the register file.

---
 rtl/wb_pkg.sv | 21 ++
 rtl/wb_fifo.sv | 42 ++++
 rtl/wb_arbiter.sv | 119 +++++++++++
 tb/tb_wb_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and defaults for the writeback arbiter.
package wb_pkg;

   localparam int unsigned QFIFO_DEPTH_DEF = 4;
   localparam int unsigned AGE_LIMIT_DEF   = 8;

   // One register file write request.
   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] wd;
   } wb_req_t;

   // Winner of the write port in the current cycle.
   typedef enum logic [1:0] {
      SRC_NONE,
      SRC_ALU,
      SRC_LD,
      SRC_Q
   } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback requests; wrap-bit pointers give full/empty.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int unsigned DEPTH = QFIFO_DEPTH_DEF
) (
   input  logic    clk,
   input  logic    reset_n,
   input  logic    push,
   input  wb_req_t push_data,
   input  logic    pop,
   output wb_req_t head,
   output logic    full,
   output logic    empty
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [PW:0] wptr_q, rptr_q;
   wb_req_t     mem_q [DEPTH];

   assign empty = (wptr_q == rptr_q);
   assign full  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
   assign head  = mem_q[rptr_q[PW-1:0]];

   // Pointer update; reset discards any stored entries.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (push && !full)  wptr_q <= wptr_q + (PW+1)'(1);
         if (pop && !empty)  rptr_q <= rptr_q + (PW+1)'(1);
      end
   end

   // Storage write; contents need no reset since the pointers gate visibility.
   always_ff @(posedge clk) begin
      if (push && !full) mem_q[wptr_q[PW-1:0]] <= push_data;
   end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU, load and quantum results onto the single
// register file write port and tracks pending long-latency destinations.
module wb_arbiter
   import wb_pkg::*;
#(
   parameter int unsigned QFIFO_DEPTH = QFIFO_DEPTH_DEF,
   parameter int unsigned AGE_LIMIT   = AGE_LIMIT_DEF
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        alu_valid,
   input  logic [4:0]  alu_rd,
   input  logic [31:0] alu_wd,
   input  logic        ld_valid,
   output logic        ld_ready,
   input  logic [4:0]  ld_rd,
   input  logic [31:0] ld_wd,
   input  logic        q_valid,
   output logic        q_ready,
   input  logic [4:0]  q_rd,
   input  logic [31:0] q_wd,
   input  logic        issue_valid,
   input  logic        issue_long,
   input  logic [4:0]  issue_rd,
   output logic [31:0] busy,
   output logic        rf_we,
   output logic [4:0]  rf_rd,
   output logic [31:0] rf_wd
);

   localparam int unsigned AW = $clog2(AGE_LIMIT + 1);

   wb_req_t     fifo_head, req;
   logic        fifo_full, fifo_empty, q_push, q_pop, q_aged;
   wb_src_e     grant;
   logic [AW-1:0] age_q, age_d;
   logic [31:0] busy_q, busy_d, set_mask, clr_mask;
   logic        rf_we_q, rf_we_d;
   logic [4:0]  rf_rd_q;
   logic [31:0] rf_wd_q;

   assign q_aged   = (age_q == AW'(AGE_LIMIT));
   assign ld_ready = !alu_valid && !q_aged;
   assign q_ready  = !fifo_full;
   assign q_push   = q_valid && q_ready;
   assign q_pop    = (grant == SRC_Q);

   wb_fifo #(
      .DEPTH (QFIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (q_push),
      .push_data ('{rd: q_rd, wd: q_wd}),
      .pop       (q_pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Grant selection: an aged quantum head jumps ahead of the load unit.
   always_comb begin
      grant = SRC_NONE;
      if (alu_valid)                     grant = SRC_ALU;
      else if (q_aged && !fifo_empty)    grant = SRC_Q;
      else if (ld_valid)                 grant = SRC_LD;
      else if (!fifo_empty)              grant = SRC_Q;
   end

   // Write port mux, age counter and scoreboard next-state.
   always_comb begin
      req = '0;
      unique case (grant)
         SRC_ALU: req = '{rd: alu_rd, wd: alu_wd};
         SRC_LD:  req = '{rd: ld_rd, wd: ld_wd};
         SRC_Q:   req = fifo_head;
         default: req = '0;
      endcase

      rf_we_d = (grant != SRC_NONE) && (req.rd != 5'd0);

      age_d = age_q;
      if (fifo_empty || q_pop) age_d = '0;
      else if (!q_aged)        age_d = age_q + AW'(1);

      set_mask = '0;
      if (issue_valid && issue_long && (issue_rd != 5'd0)) set_mask = 32'd1 << issue_rd;
      clr_mask = '0;
      if ((grant == SRC_LD) || (grant == SRC_Q)) clr_mask = 32'd1 << req.rd;
      // Set after clear so a same-edge re-issue keeps the bit pending.
      busy_d    = (busy_q & ~clr_mask) | set_mask;
      busy_d[0] = 1'b0;
   end

   // Registered write port, age counter and scoreboard.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rf_we_q <= 1'b0;
         rf_rd_q <= '0;
         rf_wd_q <= '0;
         age_q   <= '0;
         busy_q  <= '0;
      end else begin
         rf_we_q <= rf_we_d;
         if (grant != SRC_NONE) begin
            rf_rd_q <= req.rd;
            rf_wd_q <= req.wd;
         end
         age_q  <= age_d;
         busy_q <= busy_d;
      end
   end

   assign rf_we = rf_we_q;
   assign rf_rd = rf_rd_q;
   assign rf_wd = rf_wd_q;
   assign busy  = busy_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, collision, FIFO full, aging,
// scoreboard, rd=0 and mid-stream reset.
module tb_wb_arbiter;

   logic        clk, reset_n;
   logic        alu_valid, ld_valid, q_valid, issue_valid, issue_long;
   logic [4:0]  alu_rd, ld_rd, q_rd, issue_rd;
   logic [31:0] alu_wd, ld_wd, q_wd;
   logic        ld_ready, q_ready, rf_we;
   logic [31:0] busy, rf_wd;
   logic [4:0]  rf_rd;

   int checks = 0;
   int errors = 0;

   wb_arbiter #(
      .QFIFO_DEPTH (4),
      .AGE_LIMIT   (8)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .alu_valid   (alu_valid),
      .alu_rd      (alu_rd),
      .alu_wd      (alu_wd),
      .ld_valid    (ld_valid),
      .ld_ready    (ld_ready),
      .ld_rd       (ld_rd),
      .ld_wd       (ld_wd),
      .q_valid     (q_valid),
      .q_ready     (q_ready),
      .q_rd        (q_rd),
      .q_wd        (q_wd),
      .issue_valid (issue_valid),
      .issue_long  (issue_long),
      .issue_rd    (issue_rd),
      .busy        (busy),
      .rf_we       (rf_we),
      .rf_rd       (rf_rd),
      .rf_wd       (rf_wd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance to 1 ns after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n = 1'b0;
      alu_valid = 1'b1; alu_rd = '0; alu_wd = '0;
      ld_valid = 1'b0;  ld_rd = '0;  ld_wd = '0;
      q_valid = 1'b0;   q_rd = '0;   q_wd = '0;
      issue_valid = 1'b0; issue_long = 1'b0; issue_rd = '0;

      // Reset state
      #3;
      chk("rst_rf_we", rf_we, 0);
      chk("rst_busy", busy, 0);
      chk("rst_q_ready", q_ready, 1);
      chk("rst_ld_ready_alu", ld_ready, 0);
      alu_valid = 1'b0;
      #1 chk("rst_ld_ready_idle", ld_ready, 1);
      step(); step();
      reset_n = 1'b1;
      step();

      // Collision: ALU beats load
      alu_valid = 1'b1; alu_rd = 5'd5; alu_wd = 32'hAAAA;
      ld_valid = 1'b1;  ld_rd = 5'd6;  ld_wd = 32'hBBBB;
      #1 chk("col_ld_ready", ld_ready, 0);
      step();
      chk("col_we1", rf_we, 1); chk("col_rd1", rf_rd, 5); chk("col_wd1", rf_wd, 32'hAAAA);
      alu_valid = 1'b0;
      #1 chk("col_ld_ready2", ld_ready, 1);
      step();
      chk("col_we2", rf_we, 1); chk("col_rd2", rf_rd, 6); chk("col_wd2", rf_wd, 32'hBBBB);
      ld_valid = 1'b0;
      step();
      chk("col_idle_we", rf_we, 0); chk("col_hold_rd", rf_rd, 6);

      // Scoreboard
      issue_valid = 1'b1; issue_long = 1'b1; issue_rd = 5'd7;
      step();
      chk("sb_set7", busy, 32'h80);
      issue_valid = 1'b0;
      ld_valid = 1'b1; ld_rd = 5'd7; ld_wd = 32'h1234;
      step();
      chk("sb_wb_we", rf_we, 1); chk("sb_wb_rd", rf_rd, 7); chk("sb_clr7", busy, 0);
      ld_valid = 1'b0;
      issue_valid = 1'b1;
      step();
      chk("sb_reset7", busy, 32'h80);
      ld_valid = 1'b1; ld_wd = 32'h5678;
      step();
      chk("sb_same_edge_we", rf_we, 1); chk("sb_same_edge_busy", busy, 32'h80);
      issue_valid = 1'b0;
      step();
      chk("sb_final_clr", busy, 0);
      ld_valid = 1'b0;
      issue_valid = 1'b1; issue_long = 1'b0; issue_rd = 5'd9;
      step();
      chk("sb_short_noset", busy, 0);
      issue_long = 1'b1; issue_rd = 5'd3;
      step();
      issue_valid = 1'b0;
      alu_valid = 1'b1; alu_rd = 5'd3; alu_wd = 32'h33;
      step();
      chk("sb_alu_keeps", busy, 32'h8);
      alu_valid = 1'b0;
      ld_valid = 1'b1; ld_rd = 5'd3; ld_wd = 32'h3333;
      step();
      chk("sb_ld_clr3", busy, 0);
      ld_valid = 1'b0;
      step();

      // FIFO full while the ALU owns the port
      alu_valid = 1'b1; alu_rd = 5'd1; alu_wd = 32'h1;
      q_valid = 1'b1; q_rd = 5'd10; q_wd = 32'h100;
      #1 chk("ff_q_ready0", q_ready, 1);
      step(); q_rd = 5'd11; q_wd = 32'h101;
      step(); q_rd = 5'd12; q_wd = 32'h102;
      step(); q_rd = 5'd13; q_wd = 32'h103;
      step();
      q_rd = 5'd14; q_wd = 32'h104;
      alu_valid = 1'b0;
      #1 chk("ff_full", q_ready, 0);
      chk("ff_alu_we", rf_we, 1); chk("ff_alu_rd", rf_rd, 1);
      step();
      chk("ff_pop1_rd", rf_rd, 10); chk("ff_pop1_wd", rf_wd, 32'h100);
      chk("ff_ready_after_pop", q_ready, 1);
      step();
      q_valid = 1'b0;
      chk("ff_pop2_rd", rf_rd, 11);
      step(); chk("ff_pop3_rd", rf_rd, 12);
      step(); chk("ff_pop4_rd", rf_rd, 13);
      step(); chk("ff_pop5_rd", rf_rd, 14); chk("ff_pop5_wd", rf_wd, 32'h104);
      step(); chk("ff_drained_we", rf_we, 0);

      // Aging: head present, load valid every cycle
      q_valid = 1'b1; q_rd = 5'd20; q_wd = 32'hC0DE;
      ld_valid = 1'b1; ld_rd = 5'd21; ld_wd = 32'h2121;
      step();
      q_valid = 1'b0;
      chk("age_ld0_rd", rf_rd, 21);
      for (int i = 0; i < 8; i++) begin
         #1 chk("age_ld_ready", ld_ready, 1);
         step();
         chk("age_ld_rd", rf_rd, 21);
      end
      #1 chk("age_aged_ld_ready", ld_ready, 0);
      step();
      chk("age_q_we", rf_we, 1); chk("age_q_rd", rf_rd, 20); chk("age_q_wd", rf_wd, 32'hC0DE);
      #1 chk("age_ld_ready_back", ld_ready, 1);
      step();
      chk("age_ld_resume", rf_rd, 21);
      ld_valid = 1'b0;
      step();

      // rd = 0 from the quantum unit
      issue_valid = 1'b1; issue_long = 1'b1; issue_rd = 5'd4;
      step();
      issue_valid = 1'b0;
      chk("rd0_busy_set", busy, 32'h10);
      q_valid = 1'b1; q_rd = 5'd0; q_wd = 32'hDEAD;
      step();
      q_valid = 1'b0;
      chk("rd0_push_we", rf_we, 0);
      step();
      chk("rd0_pop_we", rf_we, 0); chk("rd0_busy", busy, 32'h10);
      q_valid = 1'b1; q_rd = 5'd2; q_wd = 32'h55;
      step();
      q_valid = 1'b0;
      chk("rd0_next_push_we", rf_we, 0);
      step();
      chk("rd0_next_we", rf_we, 1); chk("rd0_next_rd", rf_rd, 2); chk("rd0_next_wd", rf_wd, 32'h55);

      // Reset mid-stream with 3 entries queued behind the ALU
      alu_valid = 1'b1; alu_rd = 5'd1; alu_wd = 32'h11;
      q_valid = 1'b1; q_rd = 5'd4; q_wd = 32'h400;
      step(); q_rd = 5'd5; q_wd = 32'h500;
      step(); q_rd = 5'd6; q_wd = 32'h600;
      step();
      q_valid = 1'b0;
      chk("mid_busy_before", busy, 32'h10);
      reset_n = 1'b0;
      #1;
      chk("mid_rf_we", rf_we, 0); chk("mid_busy", busy, 0); chk("mid_q_ready", q_ready, 1);
      chk("mid_rf_rd", rf_rd, 0); chk("mid_rf_wd", rf_wd, 0); chk("mid_ld_ready_alu", ld_ready, 0);
      alu_valid = 1'b0;
      #1 chk("mid_ld_ready_idle", ld_ready, 1);
      step();
      reset_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("mid_no_stale_we", rf_we, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
